// File: rtl/nec_ir_receiver_pkg.sv
// Shared definitions for the NEC IR receiver: FSM encoding, pulse-width windows (µs) and frame size.
package nec_ir_receiver_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEAD_MARK,
    LEAD_SPACE,
    BIT_MARK,
    BIT_SPACE,
    STOP_MARK,
    REP_MARK
  } state_e;

  localparam int FRAME_BITS = 32;
  localparam int WIDTH_W    = 14;
  localparam int WIDTH_MAX  = 16383;

  localparam int LEAD_MARK_MIN  = 8000;
  localparam int LEAD_MARK_MAX  = 10000;
  localparam int LEAD_SPACE_MIN = 4000;
  localparam int LEAD_SPACE_MAX = 5000;
  localparam int REP_SPACE_MIN  = 1800;
  localparam int REP_SPACE_MAX  = 2700;
  localparam int BIT_MARK_MIN   = 400;
  localparam int BIT_MARK_MAX   = 750;
  localparam int SPACE0_MIN     = 400;
  localparam int SPACE0_MAX     = 750;
  localparam int SPACE1_MIN     = 1400;
  localparam int SPACE1_MAX     = 1900;
  localparam int STOP_MARK_MIN  = 400;
  localparam int STOP_MARK_MAX  = 750;
  localparam int TIMEOUT_US     = 12000;

  function automatic logic in_win(input logic [WIDTH_W-1:0] w, input int lo, input int hi);
    return (int'(w) >= lo) && (int'(w) <= hi);
  endfunction

endpackage

// File: rtl/nec_ir_receiver_edge_timer.sv
// Input conditioning for the IR line: synchronizer, polarity fix, edge detect and µs width counter.
module ir_edge_timer
  import nec_ir_receiver_pkg::*;
#(
  parameter int CLK_PER_US    = 100,
  parameter int IR_ACTIVE_LOW = 1,
  parameter int US_PER_TICK   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ir_i,
  output logic               mark,
  output logic               rise,
  output logic               fall,
  output logic [WIDTH_W-1:0] width_us
);

  localparam int   PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic POL   = (IR_ACTIVE_LOW != 0);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               prev_q, prev_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               tick;
  logic [WIDTH_W:0]   width_sum;

  // Synchronizer resets to the idle line level so reset release never looks like an edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= POL;
      sync2_q <= POL;
      prev_q  <= 1'b0;
      pre_q   <= '0;
      width_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      pre_q   <= pre_d;
      width_q <= width_d;
    end
  end

  assign mark     = sync2_q ^ POL;
  assign rise     = mark & ~prev_q;
  assign fall     = ~mark & prev_q;
  assign width_us = width_q;

  always_comb begin
    sync1_d   = ir_i;
    sync2_d   = sync1_q;
    prev_d    = mark;
    tick      = (pre_q == PRE_W'(CLK_PER_US - 1));
    pre_d     = tick ? '0 : pre_q + PRE_W'(1);
    width_sum = {1'b0, width_q} + (WIDTH_W+1)'(US_PER_TICK);
    width_d   = width_q;
    // The edge cycle itself is the first time slot of the new level.
    if (rise || fall) begin
      width_d = tick ? WIDTH_W'(US_PER_TICK) : '0;
    end else if (tick) begin
      width_d = (width_sum > (WIDTH_W+1)'(WIDTH_MAX)) ? WIDTH_W'(WIDTH_MAX) : width_sum[WIDTH_W-1:0];
    end
  end

endmodule

// File: rtl/nec_ir_receiver.sv
// NEC IR frame decoder: classifies mark/space widths, assembles 32-bit frames and flags repeat frames.
module nec_ir_receiver
  import nec_ir_receiver_pkg::*;
#(
  parameter int CLK_PER_US     = 100,
  parameter int IR_ACTIVE_LOW  = 1,
  parameter int CHECK_INV      = 1,
  parameter int NEWCODE_CYCLES = 4,
  parameter int US_PER_TICK    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ir_i,
  output logic [31:0] code,
  output logic        newCode,
  output logic        repeat_o,
  output logic        busy
);

  logic               mark, rise, fall;
  logic [WIDTH_W-1:0] width_us;
  logic               lvl_edge, rise_ev, fall_ev;

  state_e      state_q, state_d;
  logic [5:0]  bits_q, bits_d;
  logic [31:0] shift_q, shift_d;
  logic [31:0] code_q, code_d;
  logic [3:0]  nc_cnt_q, nc_cnt_d;
  logic        repeat_q, repeat_d;
  logic        inv_ok;

  ir_edge_timer #(
    .CLK_PER_US   (CLK_PER_US),
    .IR_ACTIVE_LOW(IR_ACTIVE_LOW),
    .US_PER_TICK  (US_PER_TICK)
  ) u_edge_timer (
    .clk     (clk),
    .rst     (rst),
    .ir_i    (ir_i),
    .mark    (mark),
    .rise    (rise),
    .fall    (fall),
    .width_us(width_us)
  );

  assign lvl_edge = rise | fall;
  assign rise_ev  = lvl_edge & mark;
  assign fall_ev  = lvl_edge & ~mark;
  assign inv_ok   = (CHECK_INV == 0) || (shift_q[15:8] == ~shift_q[7:0]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      bits_q   <= '0;
      shift_q  <= '0;
      code_q   <= '0;
      nc_cnt_q <= '0;
      repeat_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      bits_q   <= bits_d;
      shift_q  <= shift_d;
      code_q   <= code_d;
      nc_cnt_q <= nc_cnt_d;
      repeat_q <= repeat_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bits_d   = bits_q;
    shift_d  = shift_q;
    code_d   = code_q;
    nc_cnt_d = (nc_cnt_q != '0) ? nc_cnt_q - 4'd1 : '0;
    repeat_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rise_ev) state_d = LEAD_MARK;
      end
      LEAD_MARK: begin
        if (fall_ev) state_d = in_win(width_us, LEAD_MARK_MIN, LEAD_MARK_MAX) ? LEAD_SPACE : IDLE;
      end
      LEAD_SPACE: begin
        if (rise_ev) begin
          if (in_win(width_us, LEAD_SPACE_MIN, LEAD_SPACE_MAX)) begin
            state_d = BIT_MARK;
            bits_d  = '0;
            shift_d = '0;
          end else if (in_win(width_us, REP_SPACE_MIN, REP_SPACE_MAX)) begin
            state_d = REP_MARK;
          end else begin
            state_d = IDLE;
          end
        end
      end
      BIT_MARK: begin
        if (fall_ev) state_d = in_win(width_us, BIT_MARK_MIN, BIT_MARK_MAX) ? BIT_SPACE : IDLE;
      end
      BIT_SPACE: begin
        if (rise_ev) begin
          if (in_win(width_us, SPACE0_MIN, SPACE0_MAX) || in_win(width_us, SPACE1_MIN, SPACE1_MAX)) begin
            shift_d = {shift_q[30:0], in_win(width_us, SPACE1_MIN, SPACE1_MAX)};
            bits_d  = bits_q + 6'd1;
            state_d = (bits_q == 6'(FRAME_BITS - 1)) ? STOP_MARK : BIT_MARK;
          end else begin
            state_d = IDLE;
          end
        end
      end
      STOP_MARK: begin
        if (fall_ev) begin
          // Back-to-back frames restart the strobe so the consumer sees the newest word.
          if (in_win(width_us, STOP_MARK_MIN, STOP_MARK_MAX) && inv_ok) begin
            code_d   = shift_q;
            nc_cnt_d = 4'(NEWCODE_CYCLES);
          end
          state_d = IDLE;
        end
      end
      REP_MARK: begin
        if (fall_ev) begin
          repeat_d = in_win(width_us, STOP_MARK_MIN, STOP_MARK_MAX);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_q != IDLE) && !lvl_edge && (int'(width_us) >= TIMEOUT_US)) begin
      state_d = IDLE;
      bits_d  = '0;
      shift_d = '0;
    end
  end

  assign code     = code_q;
  assign newCode  = (nc_cnt_q != '0);
  assign repeat_o = repeat_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: doc/nec_ir_receiver.md
Name: nec_ir_receiver

Overview:
- Demodulated-IR front end that decodes NEC-protocol frames from a TSOP-style receiver output.
- Delivers the 32-bit frame word plus a strobe to the RGB remote controller, whose `code`/`newCode` inputs it drives directly.
- Also flags NEC repeat frames and exposes a busy indication.
- Sits between the IR receiver pin and the RGB remote controller.

Parameters:
- CLK_PER_US, 100, system clocks per 1 µs timing tick (100 MHz clock).
- IR_ACTIVE_LOW, 1, 1 = receiver output is low during a carrier burst (mark).
- CHECK_INV, 1, 1 = drop frames whose command byte does not match the inverted command byte.
- NEWCODE_CYCLES, 4, width of the newCode pulse in clocks (1..15).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- ir_i  in  1  raw demodulated IR line; asynchronous to clk.
- code  out  32  last valid frame {addr, ~addr, cmd, ~cmd}; first received bit lands in code[31].
- newCode  out  1  high for NEWCODE_CYCLES clocks when code is updated.
- repeat_o  out  1  one-clock pulse on a valid NEC repeat frame.
- busy  out  1  high while a frame is being received (state != IDLE).

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: code=0, newCode=0, repeat_o=0, busy=0, state=IDLE, all counters=0.
- Input conditioning:
  - ir_i passes through a 2-FF synchronizer, then is XORed with IR_ACTIVE_LOW, giving mark=1.
  - Edge detection runs on the synchronized signal.
- Timing:
  - The prescaler produces a 1 µs tick.
  - A 14-bit µs width counter clears on every synchronized edge and saturates at 16383.
  - On each edge, the width of the level just ended is classified.
- Classification windows (µs, inclusive):
  - lead mark 8000..10000
  - lead space 4000..5000 (frame) or 1800..2700 (repeat)
  - bit mark 400..750
  - bit space 400..750 = 0, 1400..1900 = 1
  - stop mark 400..750
- FSM states: IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK, REP_MARK.
  - IDLE: mark rising edge -> LEAD_MARK.
  - LEAD_MARK: falling edge with width in window -> LEAD_SPACE; otherwise -> IDLE.
  - LEAD_SPACE: rising edge with frame width -> BIT_MARK (bit count=0); repeat width -> REP_MARK; otherwise -> IDLE.
  - BIT_MARK: falling edge with valid width -> BIT_SPACE; otherwise -> IDLE.
  - BIT_SPACE: rising edge with 0/1 width -> shift the bit into shift[0] (left shift) and increment the count.
    - If count reaches 32 -> STOP_MARK, else -> BIT_MARK.
    - Invalid width -> IDLE.
  - STOP_MARK: falling edge with valid width -> frame complete.
    - If CHECK_INV=0, or shift[15:8] == ~shift[7:0]: load code and start the newCode pulse.
    - In all cases -> IDLE.
  - REP_MARK: falling edge with valid width -> repeat_o pulse for 1 clk, code unchanged -> IDLE.
- Timeout: in any non-IDLE state, width counter >= 12000 with no edge -> IDLE. Shift register and count are discarded; outputs are unchanged.
- Latency: code and newCode both update on the clock after the synchronized edge that ends the stop mark (3 clocks after the raw ir_i edge).
- Hand-off to the consumer:
  - code is stable for the whole newCode pulse and after its falling edge, until the next valid frame.
  - The consumer samples on the newCode falling edge.
- Overlapping frames: if a new frame completes while newCode is still high, code updates and the pulse counter restarts.
- Invalid frames and repeats never touch code.
- Reset mid-frame: all state is cleared immediately, and a partial frame is never emitted.

Decomposition:
- Shared package holds:
  - FSM state encoding.
  - All window bounds and the timeout as µs localparams.
  - FRAME_BITS=32.
- Natural sub-module: ir_edge_timer. It contains the synchronizer, polarity fix, edge detect, µs prescaler and saturating width counter.
- Outputs of ir_edge_timer: mark, rise, fall, width_us.

Test Plan:
- Valid frame 0x00FF10EF (addr 00, cmd 10) with nominal timing:
  - code=0x00FF10EF, newCode high for exactly 4 clocks, repeat_o=0.
  - busy drops after the stop mark.
- Valid frame followed 40 ms later by a repeat frame (9000 mark / 2250 space / 560 mark):
  - Exactly one repeat_o pulse.
  - code stays 0x00FF10EF, no second newCode.
- Frame 0x00FF10EE with CHECK_INV=1:
  - No newCode, code keeps its previous value.
  - With CHECK_INV=0, the same frame gives code=0x00FF10EE.
- Timing edges:
  - Frame whose bit spaces are all at 400 and 1900 µs decodes.
  - A 300 µs leader mark, or a 2000 µs bit space, aborts to IDLE with no output.
- Truncated frame (20 bits, then the line idles 15 ms):
  - Timeout returns to IDLE with no newCode.
  - The next valid frame 0x00FF40BF decodes correctly.
- rst pulsed during bit 17 of a frame:
  - All outputs read 0 during and after reset.
  - The remaining bits are ignored; the following full frame decodes normally.
